// File: rtl/vram_pixel_arbiter.sv
// rtl/vram_pixel_arbiter.sv - video RAM write-port arbiter: CPU pixel stores plus rectangle-fill engine
// Optional round-robin contention resolution: define VRAM_ARB_RR_EN.
module vram_pixel_arbiter #(
    parameter int H_RES       = 400,
    parameter int V_RES       = 240,
    parameter int COLOR_WIDTH = 3,
    parameter int ADDR_WIDTH  = 19
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   iCpuReq,
    input  logic [15:0]            iCpuCol,
    input  logic [15:0]            iCpuRow,
    input  logic [COLOR_WIDTH-1:0] iCpuColor,
    output logic                   oCpuAck,
    input  logic                   iFillStart,
    input  logic [15:0]            iFillX0,
    input  logic [15:0]            iFillX1,
    input  logic [15:0]            iFillY0,
    input  logic [15:0]            iFillY1,
    input  logic [COLOR_WIDTH-1:0] iFillColor,
    output logic                   oFillBusy,
    output logic                   oFillDone,
    output logic                   oWriteEnable,
    output logic [ADDR_WIDTH-1:0]  oWriteAddress,
    output logic [COLOR_WIDTH-1:0] oWriteData
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [31:0] H_RES32 = 32'(H_RES);
    localparam logic [31:0] V_RES32 = 32'(V_RES);
    localparam logic [15:0] X_MAX   = 16'(H_RES - 1);
    localparam logic [15:0] Y_MAX   = 16'(V_RES - 1);

    logic [1:0]             state;
    logic [15:0]            fx0, fx1, fy0, fy1;
    logic [COLOR_WIDTH-1:0] fill_color;
    logic [15:0]            x_lo, x_hi, y_hi, cur_x, cur_y;
    logic [31:0]            row_base;

    logic [15:0] sx_lo, sx_hi, sy_lo, sy_hi, sx_hi_c, sy_hi_c;
    logic        setup_clip;
    logic        cpu_in_range;
    logic        fill_req, cpu_grant, fill_grant;

    always_comb begin
        sx_lo = (fx0 <= fx1) ? fx0 : fx1;
        sx_hi = (fx0 <= fx1) ? fx1 : fx0;
        sy_lo = (fy0 <= fy1) ? fy0 : fy1;
        sy_hi = (fy0 <= fy1) ? fy1 : fy0;
        sx_hi_c = (sx_hi > X_MAX) ? X_MAX : sx_hi;
        sy_hi_c = (sy_hi > Y_MAX) ? Y_MAX : sy_hi;
        setup_clip = ({16'h0, sx_lo} >= H_RES32) || ({16'h0, sy_lo} >= V_RES32);
    end

    assign cpu_in_range = ({16'h0, iCpuCol} < H_RES32) && ({16'h0, iCpuRow} < V_RES32);
    assign fill_req     = (state == S_RUN);

`ifdef VRAM_ARB_RR_EN
    // Set when the CPU held the port last; the fill gets the next contended slot.
    logic last_cpu;
    assign cpu_grant = iCpuReq && !Reset && !(fill_req && last_cpu);

    always_ff @(posedge Clock) begin
        if (Reset)
            last_cpu <= 1'b0;
        else if (cpu_grant)
            last_cpu <= 1'b1;
        else if (fill_grant)
            last_cpu <= 1'b0;
    end
`else
    assign cpu_grant = iCpuReq && !Reset;
`endif

    assign fill_grant = fill_req && !cpu_grant;
    assign oCpuAck    = cpu_grant;
    assign oFillBusy  = (state != S_IDLE);
    assign oFillDone  = (state == S_DONE);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= S_IDLE;
            fx0        <= '0;
            fx1        <= '0;
            fy0        <= '0;
            fy1        <= '0;
            fill_color <= '0;
            x_lo       <= '0;
            x_hi       <= '0;
            y_hi       <= '0;
            cur_x      <= '0;
            cur_y      <= '0;
            row_base   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (iFillStart) begin
                        fx0        <= iFillX0;
                        fx1        <= iFillX1;
                        fy0        <= iFillY0;
                        fy1        <= iFillY1;
                        fill_color <= iFillColor;
                        state      <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    x_lo     <= sx_lo;
                    x_hi     <= sx_hi_c;
                    y_hi     <= sy_hi_c;
                    cur_x    <= sx_lo;
                    cur_y    <= sy_lo;
                    row_base <= H_RES32 * {16'h0, sy_lo};
                    state    <= setup_clip ? S_DONE : S_RUN;
                end
                S_RUN: begin
                    // Cursor only moves on a granted pixel; a CPU win leaves it frozen.
                    if (fill_grant) begin
                        if (cur_x == x_hi) begin
                            if (cur_y == y_hi) begin
                                state <= S_DONE;
                            end else begin
                                cur_x    <= x_lo;
                                cur_y    <= cur_y + 16'd1;
                                row_base <= row_base + H_RES32;
                            end
                        end else begin
                            cur_x <= cur_x + 16'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            oWriteEnable  <= 1'b0;
            oWriteAddress <= '0;
            oWriteData    <= '0;
        end else if (cpu_grant) begin
            oWriteEnable  <= cpu_in_range;
            oWriteAddress <= ADDR_WIDTH'(H_RES32 * {16'h0, iCpuRow} + {16'h0, iCpuCol});
            oWriteData    <= iCpuColor;
        end else if (fill_grant) begin
            oWriteEnable  <= 1'b1;
            oWriteAddress <= ADDR_WIDTH'(row_base + {16'h0, cur_x});
            oWriteData    <= fill_color;
        end else begin
            oWriteEnable  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vram_pixel_arbiter.sv
// tb/tb_vram_pixel_arbiter.sv - randomized self-checking bench for vram_pixel_arbiter
module tb_vram_pixel_arbiter;

    localparam int H = 400;
    localparam int V = 240;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        iCpuReq;
    logic [15:0] iCpuCol, iCpuRow;
    logic [2:0]  iCpuColor;
    logic        oCpuAck;
    logic        iFillStart;
    logic [15:0] iFillX0, iFillX1, iFillY0, iFillY1;
    logic [2:0]  iFillColor;
    logic        oFillBusy, oFillDone, oWriteEnable;
    logic [18:0] oWriteAddress;
    logic [2:0]  oWriteData;

    vram_pixel_arbiter dut (
        .Clock(Clock), .Reset(Reset),
        .iCpuReq(iCpuReq), .iCpuCol(iCpuCol), .iCpuRow(iCpuRow), .iCpuColor(iCpuColor),
        .oCpuAck(oCpuAck),
        .iFillStart(iFillStart), .iFillX0(iFillX0), .iFillX1(iFillX1),
        .iFillY0(iFillY0), .iFillY1(iFillY1), .iFillColor(iFillColor),
        .oFillBusy(oFillBusy), .oFillDone(oFillDone),
        .oWriteEnable(oWriteEnable), .oWriteAddress(oWriteAddress), .oWriteData(oWriteData)
    );

    always #5 Clock = ~Clock;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];
    int last_done_k;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: every in-range pixel of the ordered, clamped rectangle in raster order.
    task automatic model_fill(input int x0, input int x1, input int y0, input int y1);
        int xl, xh, yl, yh;
        exp_q.delete();
        xl = (x0 < x1) ? x0 : x1;
        xh = (x0 < x1) ? x1 : x0;
        yl = (y0 < y1) ? y0 : y1;
        yh = (y0 < y1) ? y1 : y0;
        if (xh > H - 1) xh = H - 1;
        if (yh > V - 1) yh = V - 1;
        if (xl >= H || yl >= V) return;
        for (int y = yl; y <= yh; y++)
            for (int x = xl; x <= xh; x++)
                exp_q.push_back(H * y + x);
    endtask

    task automatic cpu_write(input int col, input int row, input logic [2:0] color);
        bit in_range;
        in_range = (col < H) && (row < V);
        @(negedge Clock);
        iCpuReq = 1'b1; iCpuCol = col[15:0]; iCpuRow = row[15:0]; iCpuColor = color;
        #1;
        expect_eq("cpu_ack", oCpuAck, 1);
        @(negedge Clock);
        iCpuReq = 1'b0;
        expect_eq("cpu_we", oWriteEnable, in_range);
        if (in_range) begin
            expect_eq("cpu_addr", oWriteAddress, H * row + col);
            expect_eq("cpu_data", oWriteData, color);
        end
        @(negedge Clock);
        expect_eq("cpu_idle_we", oWriteEnable, 0);
    endtask

    task automatic run_fill(input int x0, input int x1, input int y0, input int y1,
                            input logic [2:0] color, input int cpu_start, input int cpu_len,
                            input bit check_timing);
        int got_fill[$], fill_k[$], got_cpu[$], exp_cpu[$];
        int n, done_k, issued, col, row;
        bit pending, prev_ack;
        logic [2:0] cc;
        model_fill(x0, x1, y0, y1);
        n = exp_q.size();
        done_k = -1; issued = 0; pending = 0; prev_ack = 0;
        @(negedge Clock);
        iFillX0 = x0[15:0]; iFillX1 = x1[15:0]; iFillY0 = y0[15:0]; iFillY1 = y1[15:0];
        iFillColor = color; iFillStart = 1'b1;
        for (int k = 1; k < 600; k++) begin
            @(negedge Clock);
            iFillStart = 1'b0;
            if (oWriteEnable) begin
                if (prev_ack) begin
                    got_cpu.push_back((int'(oWriteData) << 20) | int'(oWriteAddress));
                end else begin
                    got_fill.push_back((int'(oWriteData) << 20) | int'(oWriteAddress));
                    fill_k.push_back(k);
                end
            end
            if (oFillDone) begin
                if (done_k < 0) done_k = k;
                else expect_eq("fill_done_single_pulse", k, done_k);
            end
            if (k == 1) expect_eq("fill_busy_after_start", oFillBusy, 1);
            if (done_k >= 0 && k == done_k + 1) expect_eq("fill_busy_after_done", oFillBusy, 0);
            if (prev_ack) pending = 0;
            if (!pending && issued < cpu_len && k >= cpu_start) begin
                col = $urandom_range(0, H - 1);
                row = $urandom_range(200, V - 1);
                cc  = 3'($urandom);
                iCpuReq = 1'b1; iCpuCol = col[15:0]; iCpuRow = row[15:0]; iCpuColor = cc;
                exp_cpu.push_back((int'(cc) << 20) | (H * row + col));
                issued++;
                pending = 1;
            end else if (!pending) begin
                iCpuReq = 1'b0;
            end
            #1;
            prev_ack = iCpuReq && oCpuAck;
            if (done_k >= 0 && issued == cpu_len && !pending && k >= done_k + 1) break;
        end
        iCpuReq = 1'b0;
        last_done_k = done_k;
        expect_eq("fill_done_seen", (done_k >= 0), 1);
        expect_eq("fill_count", got_fill.size(), n);
        for (int i = 0; i < n && i < got_fill.size(); i++)
            expect_eq("fill_pixel", got_fill[i], (int'(color) << 20) | exp_q[i]);
        expect_eq("cpu_count", got_cpu.size(), cpu_len);
        for (int i = 0; i < cpu_len && i < got_cpu.size(); i++)
            expect_eq("cpu_pixel", got_cpu[i], exp_cpu[i]);
        if (check_timing) begin
            expect_eq("fill_done_cycle", done_k, (n == 0) ? 2 : n + 2);
            if (n > 0 && fill_k.size() == n) begin
                expect_eq("fill_first_write_cycle", fill_k[0], 3);
                expect_eq("fill_last_write_cycle", fill_k[n-1], done_k);
            end
        end
    endtask

    initial begin
        int wr_seen, done_seen;
        Reset = 1'b1; iCpuReq = 1'b0; iCpuCol = '0; iCpuRow = '0; iCpuColor = '0;
        iFillStart = 1'b0; iFillX0 = '0; iFillX1 = '0; iFillY0 = '0; iFillY1 = '0; iFillColor = '0;
        repeat (3) @(negedge Clock);
        expect_eq("rst_we", oWriteEnable, 0);
        expect_eq("rst_addr", oWriteAddress, 0);
        expect_eq("rst_data", oWriteData, 0);
        expect_eq("rst_ack", oCpuAck, 0);
        expect_eq("rst_busy", oFillBusy, 0);
        expect_eq("rst_done", oFillDone, 0);
        Reset = 1'b0;

        cpu_write(5, 2, 3'b101);
        cpu_write(400, 0, 3'b111);
        cpu_write(0, 240, 3'b011);

        run_fill(3, 1, 10, 11, 3'b010, 0, 0, 1);
        run_fill(398, 1000, 239, 239, 3'b110, 0, 0, 1);
        run_fill(500, 600, 0, 5, 3'b001, 0, 0, 1);

        // 4x1 fill with three CPU stores arriving mid-run; either arbitration gives 7 back-to-back writes.
        run_fill(10, 13, 20, 20, 3'b100, 3, 3, 0);
        expect_eq("contention_done_cycle", last_done_k, 9);

        // Reset during the third pixel of a 10x10 fill.
        @(negedge Clock);
        iFillX0 = 16'd50; iFillX1 = 16'd59; iFillY0 = 16'd30; iFillY1 = 16'd39;
        iFillColor = 3'b011; iFillStart = 1'b1;
        @(negedge Clock); iFillStart = 1'b0;
        repeat (3) @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        expect_eq("midrst_we", oWriteEnable, 0);
        expect_eq("midrst_addr", oWriteAddress, 0);
        expect_eq("midrst_data", oWriteData, 0);
        expect_eq("midrst_ack", oCpuAck, 0);
        expect_eq("midrst_busy", oFillBusy, 0);
        expect_eq("midrst_done", oFillDone, 0);
        Reset = 1'b0;
        wr_seen = 0; done_seen = 0;
        repeat (30) begin
            @(negedge Clock);
            if (oWriteEnable) wr_seen++;
            if (oFillDone) done_seen++;
        end
        expect_eq("midrst_no_writes", wr_seen, 0);
        expect_eq("midrst_no_done", done_seen, 0);
        run_fill(7, 9, 100, 101, 3'b101, 0, 0, 1);

        for (int it = 0; it < 30; it++) begin
            int x0, x1, y0, y1;
            case ($urandom_range(0, 2))
                0: cpu_write($urandom_range(0, 420), $urandom_range(0, 255), 3'($urandom));
                1: begin
                    x0 = $urandom_range(0, 420); x1 = x0 + $urandom_range(0, 8);
                    y0 = $urandom_range(0, 255); y1 = y0 + $urandom_range(0, 4);
                    if ($urandom_range(0, 1) == 1) run_fill(x1, x0, y1, y0, 3'($urandom), 0, 0, 1);
                    else run_fill(x0, x1, y0, y1, 3'($urandom), 0, 0, 1);
                end
                default: begin
                    x0 = $urandom_range(0, 390); x1 = x0 + $urandom_range(0, 6);
                    y0 = $urandom_range(0, 150); y1 = y0 + $urandom_range(0, 3);
                    run_fill(x0, x1, y0, y1, 3'($urandom), $urandom_range(1, 8), $urandom_range(1, 5), 0);
                end
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
